// File: rtl/inst_mem_responder.sv
// Block-read instruction memory behind the I-cache miss port: fixed-latency 128-bit block
// reads, plus a word-wide preload port that is only open while the responder is idle.
module inst_mem_responder #(
  parameter int MEM_BLOCKS = 64,
  parameter int LATENCY    = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [27:0]  mem_address,
  input  logic         mem_read,
  output logic [127:0] mem_readinst,
  output logic         mem_busywait,
  input  logic         load_en,
  input  logic [31:0]  load_addr,
  input  logic [31:0]  load_data,
  output logic         load_ready
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [IDX_W-1:0]       idx_r, idx_s;
  logic                   rd_fire_s;
  logic                   wr_s;
  logic [3:0][31:0]       mem_r [MEM_BLOCKS];
  logic                   unused_s;

  // Only the index bits of either address are decoded; the rest alias.
  assign unused_s   = ^{mem_address[27:IDX_W], load_addr[31:IDX_W+4], load_addr[1:0]};
  assign load_ready = (state_r == IDLE) & ~mem_read;
  assign wr_s       = load_en & load_ready;

  // Next-state, latency counter and combinational busywait.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    idx_s        = idx_r;
    rd_fire_s    = 1'b0;
    mem_busywait = 1'b0;
    case (state_r)
      IDLE: begin
        mem_busywait = mem_read;
        if (mem_read) begin
          state_s = BUSY;
          cnt_s   = CNT_W'(LATENCY - 1);
          idx_s   = mem_address[IDX_W-1:0];
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        mem_busywait = 1'b1;
        if (cnt_r == '0) begin
          state_s   = DONE;
          rd_fire_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      // One idle-looking cycle so a still-high mem_read is not taken as a new request.
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state and returned block; a reset mid-read abandons it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      idx_r        <= '0;
      mem_readinst <= 128'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      if (rd_fire_s) begin
        mem_readinst <= mem_r[idx_r];
      end
    end
  end

  // Program storage survives reset, so it has no reset branch.
  always_ff @(posedge clock) begin
    if (wr_s) begin
      mem_r[load_addr[IDX_W+3:4]][load_addr[3:2]] <= load_data;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: preload, read latency, address-change immunity,
// aliasing, load blocking during a read, and reset abandoning a pending read.
module tb_inst_mem_responder;

  logic         clock;
  logic         reset;
  logic [27:0]  mem_address;
  logic         mem_read;
  logic [127:0] mem_readinst;
  logic         mem_busywait;
  logic         load_en;
  logic [31:0]  load_addr;
  logic [31:0]  load_data;
  logic         load_ready;

  int checks;
  int errors;

  localparam logic [127:0] BLK0 = 128'h40208233_002081B3_00A00113_00500093;

  inst_mem_responder #(.MEM_BLOCKS(64), .LATENCY(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ready   (load_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clock);
    #1 load_en = 1'b0;
  endtask

  // mode 0: plain read; 1: address changed mid-BUSY; 2: load attempted mid-BUSY
  task automatic do_read(input string tag, input logic [27:0] addr, input logic [127:0] exp,
                         input int mode);
    int n;
    @(negedge clock);
    mem_read    = 1'b1;
    mem_address = addr;
    #1;
    n = 0;
    while (mem_busywait && n < 20) begin
      n++;
      if (n == 2 && mode == 1) mem_address = 28'h0000005;
      if (n == 2 && mode == 2) begin
        load_en   = 1'b1;
        load_addr = 32'h0;
        load_data = 32'hFFFFFFFF;
        #1 check_eq({tag, "_load_ready_busy"}, {127'd0, load_ready}, 128'd0);
      end
      @(negedge clock);
    end
    load_en = 1'b0;
    check_eq({tag, "_busy_cycles"}, 128'(n), 128'd5);
    check_eq({tag, "_data"}, mem_readinst, exp);
    @(posedge clock);
    #1 mem_read = 1'b0;
    @(negedge clock);
    check_eq({tag, "_idle_busy"}, {127'd0, mem_busywait}, 128'd0);
    check_eq({tag, "_idle_ready"}, {127'd0, load_ready}, 128'd1);
    check_eq({tag, "_data_hold"}, mem_readinst, exp);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    mem_read    = 1'b0;
    mem_address = 28'h0;
    load_en     = 1'b0;
    load_addr   = 32'h0;
    load_data   = 32'h0;
    repeat (2) @(negedge clock);
    check_eq("rst_data", mem_readinst, 128'd0);
    check_eq("rst_busy", {127'd0, mem_busywait}, 128'd0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("post_rst_data", mem_readinst, 128'd0);
    check_eq("post_rst_busy", {127'd0, mem_busywait}, 128'd0);
    check_eq("post_rst_ready", {127'd0, load_ready}, 128'd1);

    load_word(32'h0, 32'h00500093);
    load_word(32'h4, 32'h00A00113);
    load_word(32'h8, 32'h002081B3);
    load_word(32'hC, 32'h40208233);
    load_word(32'h50, 32'hDEADBEEF);
    load_word(32'h54, 32'h11111111);
    load_word(32'h58, 32'h22222222);
    load_word(32'h5C, 32'h33333333);

    do_read("rd_blk0", 28'h0000000, BLK0, 0);
    do_read("rd_blk5", 28'h0000005, 128'h33333333_22222222_11111111_DEADBEEF, 0);
    do_read("rd_addr_chg", 28'h0000000, BLK0, 1);
    do_read("rd_alias", 28'h0000040, BLK0, 0);
    do_read("rd_load_busy", 28'h0000000, BLK0, 2);
    do_read("rd_after_load", 28'h0000000, BLK0, 0);

    // Reset while the counter sits at 2 (two edges into BUSY).
    @(negedge clock);
    mem_read    = 1'b1;
    mem_address = 28'h0000000;
    repeat (2) @(negedge clock);
    #1;
    check_eq("pre_rst_busy", {127'd0, mem_busywait}, 128'd1);
    reset    = 1'b0;
    mem_read = 1'b0;
    #1;
    check_eq("midrst_busy", {127'd0, mem_busywait}, 128'd0);
    check_eq("midrst_data", mem_readinst, 128'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_idle_ready", {127'd0, load_ready}, 128'd1);
    do_read("rd_post_rst", 28'h0000000, BLK0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
